// File: rtl/tetris_pkg.sv
// Purpose: shared types and constants for the Tetris board engine and score counter.
// Latency: n/a (package only).
// Backpressure: n/a.
package tetris_pkg;

    localparam int DEF_BOARD_W = 10;
    localparam int DEF_BOARD_H = 20;
    localparam int DEF_PIECE_N = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MERGE,
        ST_SCAN,
        ST_SHIFT,
        ST_REPORT
    } state_t;

    // line_count encoding: lines cleared minus one, as the score counter expects
    localparam logic [1:0] LC_SINGLE = 2'd0;
    localparam logic [1:0] LC_DOUBLE = 2'd1;
    localparam logic [1:0] LC_TRIPLE = 2'd2;
    localparam logic [1:0] LC_TETRIS = 2'd3;

    // Flat board bit index for (row, col); row 0 is the bottom row.
    function automatic int cell_idx(input int row, input int col, input int width);
        return row * width + col;
    endfunction

endpackage

// File: rtl/tetris_piece_merge.sv
// Purpose: ORs a piece mask into the board and flags off-board / colliding cells.
// Latency: combinational.
// Backpressure: none; evaluated whenever the caller samples it.
module tetris_piece_merge
    import tetris_pkg::*;
#(
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int BOARD_H = DEF_BOARD_H,
    parameter int PIECE_N = DEF_PIECE_N,
    parameter int XW      = $clog2(BOARD_W),
    parameter int YW      = $clog2(BOARD_H)
) (
    input  logic [BOARD_W*BOARD_H-1:0] board,
    input  logic [PIECE_N*PIECE_N-1:0] mask,
    input  logic [XW-1:0]              x,
    input  logic [YW-1:0]              y,
    output logic [BOARD_W*BOARD_H-1:0] merged,
    output logic                       oob_col,
    output logic                       topout_or_overlap
);

    // Per-cell placement: columns off the side are dropped, rows off the top or
    // occupied targets are not written and count as top-out.
    always_comb begin
        merged            = board;
        oob_col           = 1'b0;
        topout_or_overlap = 1'b0;
        for (int r = 0; r < PIECE_N; r++) begin
            for (int c = 0; c < PIECE_N; c++) begin
                if (mask[r*PIECE_N+c]) begin
                    if (int'(x) + c >= BOARD_W) begin
                        oob_col = 1'b1;
                    end else if (int'(y) + r >= BOARD_H) begin
                        topout_or_overlap = 1'b1;
                    end else if (board[cell_idx(int'(y) + r, int'(x) + c, BOARD_W)]) begin
                        topout_or_overlap = 1'b1;
                    end else begin
                        merged[cell_idx(int'(y) + r, int'(x) + c, BOARD_W)] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tetris_board_engine.sv
// Purpose: settled-cell board; merges locked pieces, clears full rows, reports lines and top-out.
// Latency: done 2+min(PIECE_N, BOARD_H-piece_y) cycles after acceptance, +1 per cleared line.
// Backpressure: lock_ready low while busy or game_over; lock_valid is held until accepted.
module tetris_board_engine
    import tetris_pkg::*;
#(
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int BOARD_H = DEF_BOARD_H,
    parameter int PIECE_N = DEF_PIECE_N,
    parameter int XW      = $clog2(BOARD_W),
    parameter int YW      = $clog2(BOARD_H),
    parameter int LW      = $clog2(PIECE_N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lock_valid,
    output logic                       lock_ready,
    input  logic [PIECE_N*PIECE_N-1:0] piece_mask,
    input  logic [XW-1:0]              piece_x,
    input  logic [YW-1:0]              piece_y,
    input  logic                       clear_board,
    output logic [BOARD_W*BOARD_H-1:0] board_out,
    output logic                       busy,
    output logic                       done,
    output logic                       hit,
    output logic [LW-1:0]              line_count,
    output logic                       game_over,
    output logic                       lock_err
);

    // Scan index must be able to reach BOARD_H; rem/count must reach PIECE_N.
    localparam int IW = YW + 1;
    localparam int RW = $clog2(PIECE_N + 1);
    localparam logic [IW-1:0] ROWS_I  = IW'(BOARD_H);
    localparam logic [RW-1:0] PIECE_R = RW'(PIECE_N);

    state_t                       state_q, state_d;
    logic [BOARD_W*BOARD_H-1:0]   board_q;
    logic [BOARD_W*BOARD_H-1:0]   merged;
    logic [BOARD_W*BOARD_H-1:0]   shifted;
    logic [BOARD_W*BOARD_H-1:0]   board_down;
    logic [PIECE_N*PIECE_N-1:0]   mask_q;
    logic [XW-1:0]                x_q;
    logic [YW-1:0]                y_q;
    logic [IW-1:0]                idx_q;
    logic [RW-1:0]                rem_q;
    logic [RW-1:0]                cnt_q;
    logic                         game_over_q;
    logic                         oob_col;
    logic                         topout;
    logic                         row_full;
    logic                         scan_end;
    logic                         accept;

    tetris_piece_merge #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H),
        .PIECE_N (PIECE_N),
        .XW      (XW),
        .YW      (YW)
    ) u_merge (
        .board             (board_q),
        .mask              (mask_q),
        .x                 (x_q),
        .y                 (y_q),
        .merged            (merged),
        .oob_col           (oob_col),
        .topout_or_overlap (topout)
    );

    assign board_down = board_q >> BOARD_W;
    assign scan_end   = (idx_q >= ROWS_I) || (rem_q == '0);
    assign accept     = (state_q == ST_IDLE) && !game_over_q && !clear_board && lock_valid;
    assign board_out  = board_q;
    assign game_over  = game_over_q;

    // Row under the scan index is full, and the board with that row removed.
    always_comb begin
        row_full = 1'b0;
        shifted  = board_q;
        for (int k = 0; k < BOARD_H; k++) begin
            if (IW'(k) == idx_q) begin
                row_full = &board_q[k*BOARD_W +: BOARD_W];
            end
            if (IW'(k) >= idx_q) begin
                shifted[k*BOARD_W +: BOARD_W] = board_down[k*BOARD_W +: BOARD_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_d    = state_q;
        done       = 1'b0;
        hit        = 1'b0;
        line_count = '0;
        lock_err   = 1'b0;
        busy       = (state_q != ST_IDLE);
        lock_ready = (state_q == ST_IDLE) && !game_over_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_MERGE;
            ST_MERGE: begin
                lock_err = oob_col;
                state_d  = ST_SCAN;
            end
            ST_SCAN: begin
                if (scan_end)      state_d = ST_REPORT;
                else if (row_full) state_d = ST_SHIFT;
            end
            ST_SHIFT:  state_d = ST_SCAN;
            ST_REPORT: begin
                done = 1'b1;
                if (cnt_q != '0) begin
                    hit        = 1'b1;
                    line_count = LW'(cnt_q - RW'(1));
                end
                state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Board, operand latches, scan bookkeeping and sticky top-out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_q     <= '0;
            mask_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            game_over_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear_board) begin
                        board_q     <= '0;
                        game_over_q <= 1'b0;
                    end else if (accept) begin
                        mask_q <= piece_mask;
                        x_q    <= piece_x;
                        y_q    <= piece_y;
                    end
                end
                ST_MERGE: begin
                    board_q <= merged;
                    if (topout) game_over_q <= 1'b1;
                    idx_q   <= {1'b0, y_q};
                    rem_q   <= PIECE_R;
                    cnt_q   <= '0;
                end
                ST_SCAN: begin
                    if (!scan_end && !row_full) begin
                        idx_q <= idx_q + IW'(1);
                        rem_q <= rem_q - RW'(1);
                    end
                end
                ST_SHIFT: begin
                    board_q <= shifted;
                    cnt_q   <= cnt_q + RW'(1);
                    rem_q   <= rem_q - RW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_board_engine.sv
// Purpose: directed self-checking bench for tetris_board_engine at default size.
// Latency: counts cycles from the first cycle after the accepting edge (cycle 0 = MERGE).
// Backpressure: drives lock_valid one cycle at a time and waits for done before the next lock.
module tb_tetris_board_engine;
    import tetris_pkg::*;

    localparam int W = 10;
    localparam int H = 20;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           lock_valid = 1'b0;
    logic           lock_ready;
    logic [N*N-1:0] piece_mask = '0;
    logic [3:0]     piece_x = '0;
    logic [4:0]     piece_y = '0;
    logic           clear_board = 1'b0;
    logic [W*H-1:0] board_out;
    logic           busy;
    logic           done;
    logic           hit;
    logic [1:0]     line_count;
    logic           game_over;
    logic           lock_err;

    int errors = 0;
    int checks = 0;

    tetris_board_engine dut (
        .clk         (clk),
        .rst         (rst),
        .lock_valid  (lock_valid),
        .lock_ready  (lock_ready),
        .piece_mask  (piece_mask),
        .piece_x     (piece_x),
        .piece_y     (piece_y),
        .clear_board (clear_board),
        .board_out   (board_out),
        .busy        (busy),
        .done        (done),
        .hit         (hit),
        .line_count  (line_count),
        .game_over   (game_over),
        .lock_err    (lock_err)
    );

    always #5 clk = ~clk;

    // Drive one lock and wait for done; dc = -1 when done never arrives.
    task automatic do_lock(input logic [15:0] m, input logic [3:0] x, input logic [4:0] y,
                           output int dc, output logic h, output logic [1:0] lc, output logic err);
        dc = -1; h = 1'b0; lc = 2'b0; err = 1'b0;
        @(negedge clk);
        piece_mask = m; piece_x = x; piece_y = y; lock_valid = 1'b1;
        @(posedge clk); #1;
        lock_valid = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (lock_err) err = 1'b1;
            if (done) begin
                dc = cyc; h = hit; lc = line_count;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // Rows 0-3 filled in columns 0-8 using three non-clearing locks.
    task automatic fill_rows4();
        int dc; logic h; logic [1:0] lc; logic err;
        do_lock(16'hFFFF, 4'd0, 5'd0, dc, h, lc, err);
        do_lock(16'hFFFF, 4'd4, 5'd0, dc, h, lc, err);
        do_lock(16'h1111, 4'd8, 5'd0, dc, h, lc, err);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (board_out !== '0 || lock_ready !== 1'b1 || busy !== 1'b0 || hit !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset: board=%h ready=%b busy=%b hit=%b go=%b, want 0/1/0/0/0",
                     board_out, lock_ready, busy, hit, game_over);
        end
    endtask

    task automatic test_single_lock();
        int dc; logic h; logic [1:0] lc; logic err;
        logic [W*H-1:0] exp_b;
        exp_b = '0; exp_b[3:0] = 4'hF;
        do_lock(16'h000F, 4'd0, 5'd0, dc, h, lc, err);
        checks++;
        if (dc !== 6) begin errors++; $display("FAIL single_latency: done at %0d, want 6", dc); end
        checks++;
        if (h !== 1'b0 || lc !== 2'd0 || err !== 1'b0) begin
            errors++; $display("FAIL single_flags: hit=%b lc=%0d err=%b, want 0 0 0", h, lc, err);
        end
        checks++;
        if (board_out !== exp_b) begin errors++; $display("FAIL single_board: %h want %h", board_out, exp_b); end
    endtask

    task automatic test_line_clear();
        int dc; logic h; logic [1:0] lc; logic err;
        logic [W*H-1:0] exp_b;
        exp_b = '0; exp_b[7:0] = 8'hFF;
        do_lock(16'h000F, 4'd4, 5'd0, dc, h, lc, err);
        checks++;
        if (board_out !== exp_b) begin errors++; $display("FAIL clear_pre_board: %h want %h", board_out, exp_b); end
        do_lock(16'h0003, 4'd8, 5'd0, dc, h, lc, err);
        checks++;
        if (dc !== 7 || h !== 1'b1 || lc !== LC_SINGLE) begin
            errors++; $display("FAIL clear_single: done=%0d hit=%b lc=%0d, want 7 1 0", dc, h, lc);
        end
        checks++;
        if (board_out !== '0) begin errors++; $display("FAIL clear_board_empty: %h want 0", board_out); end
    endtask

    task automatic test_tetris();
        int dc; logic h; logic [1:0] lc; logic err;
        logic [W*H-1:0] exp_b;
        exp_b = '0;
        for (int r = 0; r < 4; r++) exp_b[r*W +: 9] = 9'h1FF;
        fill_rows4();
        checks++;
        if (board_out !== exp_b) begin errors++; $display("FAIL tetris_fill: %h want %h", board_out, exp_b); end
        do_lock(16'h1111, 4'd9, 5'd0, dc, h, lc, err);
        checks++;
        if (dc !== 10 || h !== 1'b1 || lc !== LC_TETRIS) begin
            errors++; $display("FAIL tetris_report: done=%0d hit=%b lc=%0d, want 10 1 3", dc, h, lc);
        end
        checks++;
        if (board_out !== '0) begin errors++; $display("FAIL tetris_board: %h want 0", board_out); end
    endtask

    task automatic test_topout();
        int dc; logic h; logic [1:0] lc; logic err;
        logic seen_busy;
        do_lock(16'hFF00, 4'd0, 5'd18, dc, h, lc, err);
        checks++;
        if (dc !== 4 || h !== 1'b0) begin errors++; $display("FAIL topout_done: done=%0d hit=%b, want 4 0", dc, h); end
        checks++;
        if (game_over !== 1'b1 || lock_ready !== 1'b0 || board_out !== '0) begin
            errors++; $display("FAIL topout_flags: go=%b ready=%b board=%h, want 1 0 0", game_over, lock_ready, board_out);
        end
        seen_busy = 1'b0;
        @(negedge clk);
        piece_mask = 16'h000F; piece_x = 4'd0; piece_y = 5'd0; lock_valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy) seen_busy = 1'b1;
        end
        lock_valid = 1'b0;
        checks++;
        if (seen_busy !== 1'b0 || board_out !== '0) begin
            errors++; $display("FAIL topout_ignore: busy_seen=%b board=%h, want 0 0", seen_busy, board_out);
        end
        @(negedge clk); clear_board = 1'b1;
        @(negedge clk); clear_board = 1'b0;
        checks++;
        if (game_over !== 1'b0 || lock_ready !== 1'b1 || board_out !== '0) begin
            errors++; $display("FAIL topout_clear: go=%b ready=%b board=%h, want 0 1 0", game_over, lock_ready, board_out);
        end
    endtask

    task automatic test_clear_priority();
        int dc; logic h; logic [1:0] lc; logic err;
        do_lock(16'h000F, 4'd0, 5'd0, dc, h, lc, err);
        @(negedge clk);
        piece_mask = 16'h000F; piece_x = 4'd4; piece_y = 5'd0;
        lock_valid = 1'b1; clear_board = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (board_out !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL clear_priority: board=%h busy=%b, want 0 0", board_out, busy);
        end
        lock_valid = 1'b0; clear_board = 1'b0;
    endtask

    task automatic test_lock_err();
        int dc; logic h; logic [1:0] lc; logic err;
        logic [W*H-1:0] exp_b;
        exp_b = '0; exp_b[9:8] = 2'b11;
        do_lock(16'h000F, 4'd8, 5'd0, dc, h, lc, err);
        checks++;
        if (err !== 1'b1 || dc !== 6) begin errors++; $display("FAIL lock_err_pulse: err=%b done=%0d, want 1 6", err, dc); end
        checks++;
        if (board_out !== exp_b || game_over !== 1'b0) begin
            errors++; $display("FAIL lock_err_board: %h go=%b, want %h 0", board_out, game_over, exp_b);
        end
        @(negedge clk); clear_board = 1'b1;
        @(negedge clk); clear_board = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        int dc; logic h; logic [1:0] lc; logic err;
        logic seen_done;
        fill_rows4();
        @(negedge clk);
        piece_mask = 16'h1111; piece_x = 4'd9; piece_y = 5'd0; lock_valid = 1'b1;
        @(posedge clk); #1;
        lock_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midshift_busy: busy=%b, want 1", busy); end
        rst = 1'b1;
        #1;
        checks++;
        if (board_out !== '0 || busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || lock_ready !== 1'b1) begin
            errors++; $display("FAIL midshift_reset: board=%h busy=%b done=%b hit=%b ready=%b",
                               board_out, busy, done, hit, lock_ready);
        end
        @(negedge clk); rst = 1'b0;
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || hit) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin errors++; $display("FAIL midshift_no_done: saw done/hit=%b, want 0", seen_done); end
        do_lock(16'h000F, 4'd0, 5'd0, dc, h, lc, err);
        checks++;
        if (dc !== 6 || board_out[W*H-1:0] !== {{(W*H-4){1'b0}}, 4'hF}) begin
            errors++; $display("FAIL midshift_recover: done=%0d board=%h, want 6 f", dc, board_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_lock();
        test_line_clear();
        test_tetris();
        test_topout();
        test_clear_priority();
        test_lock_err();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tetris_board_engine.md
Name: tetris_board_engine

Overview:
Parametrised static-board engine for the Tetris core. It owns the settled-cell board and accepts lock requests for a landed piece. Each lock merges the piece, scans and clears full rows, and shifts the rows above down. It reports cleared lines in the hit/lineCount encoding used by the score counter, and flags top-out. It sits between the piece-movement logic (upstream collision checks) and the scorer/display.

Parameters:
BOARD_W, 10, board columns
BOARD_H, 20, board rows (row 0 = bottom)
PIECE_N, 4, piece bounding box edge; mask is PIECE_N x PIECE_N
XW, $clog2(BOARD_W), piece_x width (derived)
YW, $clog2(BOARD_H), piece_y width (derived)
LW, $clog2(PIECE_N), line_count width (derived)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
lock_valid  in  1  lock request; held with operands until accepted
lock_ready  out  1  engine idle and not game_over
piece_mask  in  PIECE_N*PIECE_N  bit r*PIECE_N+c = cell at piece row r, col c
piece_x  in  XW  board column of mask col 0
piece_y  in  YW  board row of mask row 0
clear_board  in  1  synchronous board wipe; honoured only in IDLE
board_out  out  BOARD_W*BOARD_H  bit row*BOARD_W+col; registered
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse: lock fully processed
hit  out  1  one-cycle pulse coincident with done when ≥1 line cleared
line_count  out  LW  lines cleared minus 1 (0=single … 3=four); valid with hit, else 0
game_over  out  1  sticky top-out / overlap flag
lock_err  out  1  one-cycle pulse: set cell fell outside columns (dropped)

Behaviour:
- Reset (async): board_out=0, game_over=0, busy=0, done=0, hit=0, line_count=0, lock_err=0, lock_ready=1, FSM=IDLE.
- FSM states: IDLE, MERGE, SCAN, SHIFT, REPORT.
- IDLE:
  - lock_valid & lock_ready → latch operands, go to MERGE.
  - clear_board → board=0, game_over=0; clear_board has priority over lock_valid in the same cycle.
- MERGE (1 cycle): each set mask cell maps to (piece_y+r, piece_x+c).
  - col ≥ BOARD_W: cell dropped, lock_err pulses.
  - row ≥ BOARD_H, or target already occupied: cell not written, game_over set.
  - All other cells ORed into the board.
  - Init scan index = piece_y, rem = PIECE_N, count = 0 → SCAN.
- SCAN (1 cycle per row):
  - index ≥ BOARD_H or rem == 0 → REPORT.
  - Row[index] all ones → SHIFT.
  - Otherwise index++, rem-- and stay in SCAN.
- SHIFT (1 cycle): rows index+1..BOARD_H-1 move down one, top row zeroed, count++, rem--, index unchanged → SCAN. The row now at index is re-examined.
- REPORT (1 cycle): done=1. If count > 0: hit=1, line_count=count-1. → IDLE.
- Latency from acceptance cycle 0:
  - No clear: done at cycle 2+min(PIECE_N, BOARD_H-piece_y).
  - Each cleared line adds 1 cycle.
  - Max at defaults: done at cycle 10.
- lock_valid while busy or game_over is not accepted; no state change.
- game_over is cleared only by clear_board or rst.
- Reset mid-operation: immediate return to reset values. A partially shifted board is discarded and no done/hit is emitted.
- count never exceeds PIECE_N, so line_count cannot overflow.

Decomposition:
- Package tetris_pkg holds:
  - default BOARD_W/BOARD_H/PIECE_N
  - FSM state enum
  - cell-index function row*BOARD_W+col
  - line_count encoding constants shared with the score counter
- One natural sub-module, tetris_piece_merge: combinational. Takes board, mask, x, y and produces the merged board, oob_col, and topout_or_overlap flags.

Test Plan:
1. Reset, then idle 5 cycles → board_out=0, lock_ready=1, busy=0, hit=0, game_over=0.
2. Empty board; lock mask row0=1111, x=0, y=0 → board bits 0–3 set, done at cycle 6, hit=0, line_count=0.
3. Lock row0=1111 at x=0, then at x=4, then row0=1100 at x=8 → third lock gives hit=1, line_count=0, row 0 zero, board empty.
4. Rows 0–3 filled cols 0–8; lock vertical I (col 0, rows 0–3) at x=9, y=0 → done and hit at cycle 10, line_count=2'b11, board all zero.
5. Lock mask rows 2–3 set at y=18 → game_over=1, lock_ready=0. Next lock_valid is ignored. clear_board → board=0, game_over=0, lock_ready=1.
6. Other boundary cases:
   - Assert rst during SHIFT of scenario 4 → board=0, IDLE, no done/hit.
   - Lock row0=1111 at x=8 → lock_err pulse, only cols 8–9 set.
